// File: rtl/mips_div_pkg.sv
// Shared definitions for the sequential MIPS DIV/DIVU divider.
// Holds operand/counter widths, the divide-by-zero quotient and FSM states.
// Imported by mips_div_seq and mips_div_clz.
package mips_div_pkg;

  localparam int WIDTH = 32;   // operand width (clz is fixed at 32 bits)
  localparam int CNT_W = 6;    // iteration counter / clz result width

  localparam logic [WIDTH-1:0] DIV0_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/mips_div_clz.sv
// Count leading zeros of a 32-bit word; all-zero input returns 32.
// Ports: in[31:0] word to scan, cnt[5:0] number of leading zero bits.
// Purely combinational.
module mips_div_clz
  import mips_div_pkg::*;
(
  input  logic [WIDTH-1:0] in,
  output logic [CNT_W-1:0] cnt
);

  // Scan upward so the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/mips_div_seq.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: q = LO (quotient), r = HI (remainder).
// Ports: clk, rst (sync, active-high); start/sign/a/b request; busy, done pulse,
//        q, r, div_by_zero results held until the next accepted start.
// Build option MIPS_DIV_EARLY_OUT_EN: clz-normalised dividend so small dividends
// finish early (K = 32 - clz(|a|)); without it K = 32 for non-trivial operands.
module mips_div_seq
  import mips_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  state_t           state;
  logic             neg_q;    // quotient needs negation
  logic             neg_r;    // remainder needs negation (follows dividend)
  logic             dz;
  logic             fix_ph;   // FIX phase: 0 = write results, 1 = raise done
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] amag;
  logic [WIDTH-1:0] bmag;
  logic [WIDTH-1:0] dvd;      // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] n;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   rem_sh;   // partial remainder after the shift, may reach 33 bits
  logic             fits;
  logic [WIDTH-1:0] rem_sub;

  // 0x80000000 maps to itself, which is the right unsigned magnitude.
  assign a_abs = (sign && a[WIDTH-1]) ? -a : a;
  assign b_abs = (sign && b[WIDTH-1]) ? -b : b;

`ifdef MIPS_DIV_EARLY_OUT_EN
  mips_div_clz u_clz (
    .in  (amag),
    .cnt (n)
  );
`else
  assign n = '0;
`endif

  // Restoring step: the difference always fits in 32 bits when the trial succeeds
  // because the previous remainder is below |b|.
  always_comb begin
    rem_sh  = {rem, dvd[WIDTH-1]};
    fits    = (rem_sh >= {1'b0, bmag});
    rem_sub = rem_sh[WIDTH-1:0] - bmag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      fix_ph      <= 1'b0;
      a_raw       <= '0;
      amag        <= '0;
      bmag        <= '0;
      dvd         <= '0;
      rem         <= '0;
      k           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg_q  <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= sign & a[WIDTH-1];
            a_raw  <= a;
            amag   <= a_abs;
            bmag   <= b_abs;
            dz     <= 1'b0;
            fix_ph <= 1'b0;
            busy   <= 1'b1;
            state  <= PREP;
          end
        end

        PREP: begin
          if (bmag == '0) begin
            dz    <= 1'b1;
            k     <= '0;
            state <= FIX;
          end else if (amag == '0) begin
            dvd   <= '0;
            rem   <= '0;
            k     <= '0;
            state <= FIX;
          end else begin
            // Leading zeros would only produce zero quotient bits; skip them.
            dvd   <= amag << n;
            rem   <= '0;
            k     <= CNT_W'(WIDTH) - n;
            state <= ITER;
          end
        end

        ITER: begin
          if (fits) begin
            rem <= rem_sub;
            dvd <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b0};
          end
          k <= k - 1'b1;
          if (k == CNT_W'(1)) state <= FIX;
        end

        FIX: begin
          if (!fix_ph) begin
            if (dz) begin
              q <= DIV0_Q;
              r <= a_raw;
            end else begin
              q <= neg_q ? -dvd : dvd;
              r <= neg_r ? -rem : rem;
            end
            div_by_zero <= dz;
            fix_ph      <= 1'b1;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div_seq.sv
// Self-checking bench for mips_div_seq: directed cases plus a random sweep,
// expected results queued at issue time and compared when done pulses.
module tb_mips_div_seq;
  import mips_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        div_by_zero;

  mips_div_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sign        (sign),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;   // cycles from accepting edge to done
    int          at;    // absolute cycle at which done is expected
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int tb_clz(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return 31 - i;
    return 32;
  endfunction

  function automatic int lat_of(input logic [31:0] mag);
    if (mag == 0) return 3;
`ifdef MIPS_DIV_EARLY_OUT_EN
    return 32 - tb_clz(mag) + 3;
`else
    return 35;
`endif
  endfunction

  // Reference model: 64-bit signed arithmetic cannot overflow on 32-bit operands.
  function automatic exp_t model(input logic s, input logic [31:0] av, input logic [31:0] bv);
    exp_t   e;
    longint sa, sbv;
    logic [31:0] am;
    e.at = 0;
    if (bv == 0) begin
      e.q = 32'hFFFF_FFFF; e.r = av; e.dz = 1'b1; e.lat = 3;
    end else begin
      sa  = s ? {{32{av[31]}}, av} : {32'b0, av};
      sbv = s ? {{32{bv[31]}}, bv} : {32'b0, bv};
      e.q  = 32'(sa / sbv);
      e.r  = 32'(sa % sbv);
      e.dz = 1'b0;
      am   = (s && av[31]) ? 32'(-sa) : av;
      e.lat = lat_of(am);
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] eq, input logic [31:0] er, input logic edz, input int lat);
    exp_t e;
    e.q = eq; e.r = er; e.dz = edz; e.lat = lat; e.at = 0;
    return e;
  endfunction

  // Called at a negedge; returns one negedge after the start was sampled.
  task automatic issue(input logic s, input logic [31:0] av, input logic [31:0] bv, input exp_t e);
    int guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("idle_wait", {63'b0, busy}, 64'd0);
    start = 1'b1; sign = s; a = av; b = bv;
    e.at = cyc + 1 + e.lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("q", {32'b0, q}, {32'b0, e.q});
        check("r", {32'b0, r}, {32'b0, e.r});
        check("div_by_zero", {63'b0, div_by_zero}, {63'b0, e.dz});
        check("latency", 64'(cyc), 64'(e.at));
        check("busy_at_done", {63'b0, busy}, 64'd0);
      end
    end
  end

  initial begin
    int guard;
    logic        s;
    logic [31:0] av, bv;

    repeat (2) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_q", {32'b0, q}, 64'd0);
    check("rst_r", {32'b0, r}, 64'd0);
    check("rst_dz", {63'b0, div_by_zero}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with hand-derived results.
`ifdef MIPS_DIV_EARLY_OUT_EN
    issue(1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, 10));
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 6));
`else
    issue(1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, 35));
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 35));
`endif
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 32'd0, 1'b0, 35));
    issue(1'b0, 32'h0000_1234, 32'd0, mk(32'hFFFF_FFFF, 32'h1234, 1'b1, 3));
    issue(1'b1, 32'd0, 32'd5, mk(32'd0, 32'd0, 1'b0, 3));

    // Start pulsed mid-operation must be ignored.
`ifdef MIPS_DIV_EARLY_OUT_EN
    issue(1'b0, 32'd1000, 32'd3, mk(32'd333, 32'd1, 1'b0, 13));
`else
    issue(1'b0, 32'd1000, 32'd3, mk(32'd333, 32'd1, 1'b0, 35));
`endif
    repeat (3) @(negedge clk);
    start = 1'b1; sign = 1'b1; a = 32'd55; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    // Issued while the previous op drains, so this start lands on its done cycle.
    issue(1'b1, 32'hFFFF_FF9C, 32'd7, model(1'b1, 32'hFFFF_FF9C, 32'd7));

    // Reset mid-operation: no done, outputs cleared.
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, mk(32'hFFFF_FFFF, 32'd0, 1'b0, 35));
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_q", {32'b0, q}, 64'd0);
    check("midrst_r", {32'b0, r}, 64'd0);
    check("midrst_done", {63'b0, done}, 64'd0);
    repeat (40) @(negedge clk);
`ifdef MIPS_DIV_EARLY_OUT_EN
    issue(1'b0, 32'd9, 32'd4, mk(32'd2, 32'd1, 1'b0, 7));
`else
    issue(1'b0, 32'd9, 32'd4, mk(32'd2, 32'd1, 1'b0, 35));
`endif

    // Random sweep against the reference model.
    for (int i = 0; i < 200; i++) begin
      s  = 1'($urandom_range(0, 1));
      av = $urandom >> $urandom_range(0, 31);
      bv = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) bv = 32'd0;
      if ($urandom_range(0, 15) == 0) av = 32'd0;
      if ($urandom_range(0, 3) == 0) bv = -bv;
      if ($urandom_range(0, 3) == 0) av = -av;
      issue(s, av, bv, model(s, av, bv));
    end

    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
